// File: rtl/cam_capture_binarize_pkg.sv
// Shared frame geometry and FSM state type for the camera capture/binarize slice.
package cam_pkg;
  localparam int unsigned FRAME_W   = 160;
  localparam int unsigned FRAME_H   = 120;
  localparam int unsigned FRAME_PIX = FRAME_W * FRAME_H;
  localparam int unsigned ADDR_W    = 17;

  typedef enum logic [1:0] {SYNC, VBLANK, CAPTURE} cam_state_t;
endpackage

// File: rtl/cam_capture_binarize_if.sv
// Pixel write bus from the capture stage into the 1-bit ping-pong frame buffer.
interface cam_capture_binarize_if #(
  parameter int unsigned ADDR_W = cam_pkg::ADDR_W
);
  logic [ADDR_W-1:0] cam_wr_addr;
  logic              cam_wr_data;
  logic              cam_wr_en;
  logic              cam_frame_done;
  logic              frame_err;

  modport master (output cam_wr_addr, cam_wr_data, cam_wr_en, cam_frame_done, frame_err);
  modport slave  (input  cam_wr_addr, cam_wr_data, cam_wr_en, cam_frame_done, frame_err);
endinterface

// File: rtl/cam_capture_binarize_input_sync.sv
// Resynchronises the asynchronous camera bus into clk and detects pclk/vsync edges.
module cam_input_sync
  import cam_pkg::*;
#(
  parameter int unsigned SYNC_STG = 2
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       pclk,
  input  logic       vsync,
  input  logic       href,
  input  logic [7:0] d,
  output logic [7:0] d_sync,
  output logic       href_sync,
  output logic       pclk_rise,
  output logic       vsync_rise,
  output logic       vsync_fall
);
  // bit 10 pclk, bit 9 vsync, bit 8 href, bits 7:0 data
  logic [10:0] stg [SYNC_STG];
  logic        pclk_q;
  logic        vsync_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int unsigned i = 0; i < SYNC_STG; i++) stg[i] <= '0;
      pclk_q  <= 1'b0;
      vsync_q <= 1'b0;
    end else begin
      stg[0] <= {pclk, vsync, href, d};
      for (int unsigned i = 1; i < SYNC_STG; i++) stg[i] <= stg[i-1];
      pclk_q  <= stg[SYNC_STG-1][10];
      vsync_q <= stg[SYNC_STG-1][9];
    end
  end

  assign d_sync     = stg[SYNC_STG-1][7:0];
  assign href_sync  = stg[SYNC_STG-1][8];
  assign pclk_rise  =  stg[SYNC_STG-1][10] & ~pclk_q;
  assign vsync_rise =  stg[SYNC_STG-1][9]  & ~vsync_q;
  assign vsync_fall = ~stg[SYNC_STG-1][9]  &  vsync_q;
endmodule

// File: rtl/cam_capture_binarize.sv
// OV7670 YUV422 capture: keeps luma bytes, thresholds them to 1 bit and emits pixel writes.
module cam_capture_binarize
  import cam_pkg::*;
#(
  parameter int unsigned FRAME_W  = cam_pkg::FRAME_W,
  parameter int unsigned FRAME_H  = cam_pkg::FRAME_H,
  parameter int unsigned ADDR_W   = cam_pkg::ADDR_W,
  parameter int unsigned SYNC_STG = 2
) (
  input  logic                          clk,
  input  logic                          nreset,
  input  logic                          cam_pclk,
  input  logic                          cam_vsync,
  input  logic                          cam_href,
  input  logic [7:0]                    cam_d,
  input  logic                          capture_en,
  input  logic [7:0]                    threshold,
  cam_capture_binarize_if.master        wr
);
  localparam logic [ADDR_W-1:0] PIX = ADDR_W'(FRAME_W * FRAME_H);

  logic [7:0]        d_sync;
  logic              href_sync;
  logic              pclk_rise;
  logic              vsync_rise;
  logic              vsync_fall;
  cam_state_t        state;
  logic              phase;
  logic [ADDR_W-1:0] cnt;

  cam_input_sync #(.SYNC_STG(SYNC_STG)) u_sync (
    .clk        (clk),
    .nreset     (nreset),
    .pclk       (cam_pclk),
    .vsync      (cam_vsync),
    .href       (cam_href),
    .d          (cam_d),
    .d_sync     (d_sync),
    .href_sync  (href_sync),
    .pclk_rise  (pclk_rise),
    .vsync_rise (vsync_rise),
    .vsync_fall (vsync_fall)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state             <= SYNC;
      phase             <= 1'b0;
      cnt               <= '0;
      wr.cam_wr_addr    <= '0;
      wr.cam_wr_data    <= 1'b0;
      wr.cam_wr_en      <= 1'b0;
      wr.cam_frame_done <= 1'b0;
      wr.frame_err      <= 1'b0;
    end else begin
      wr.cam_wr_en      <= 1'b0;
      wr.cam_frame_done <= 1'b0;
      wr.frame_err      <= 1'b0;
      case (state)
        SYNC: if (vsync_rise) state <= VBLANK;
        VBLANK: begin
          if (vsync_fall && capture_en) begin
            state <= CAPTURE;
            cnt   <= '0;
          end
        end
        CAPTURE: begin
          // Frame-end check takes priority; a coincident pixel is dropped.
          if (vsync_rise) begin
            state <= VBLANK;
            if (cnt == PIX) wr.cam_frame_done <= 1'b1;
            else            wr.frame_err      <= 1'b1;
          end else if (pclk_rise && href_sync) begin
            phase <= ~phase;
            if (!phase && cnt < PIX) begin
              wr.cam_wr_en   <= 1'b1;
              wr.cam_wr_data <= (d_sync >= threshold);
              wr.cam_wr_addr <= cnt;
              cnt            <= cnt + 1'b1;
            end
          end
        end
        default: state <= SYNC;
      endcase
      if (!href_sync || state != CAPTURE) phase <= 1'b0;
    end
  end
endmodule
